// File: rtl/special_case_mult_unit.sv
// Special-operand detector for the FP multiplier: classifies both operands, forms the
// special-case product word and flags, and carries them through a short valid-strobed pipeline.
module special_case_mult_unit #(
   parameter int unsigned W      = 32,
   parameter int unsigned EW     = 8,
   parameter int unsigned SW     = 23,
   parameter int unsigned STAGES = 1,
   parameter bit          FTZ    = 1'b1
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         load,
   input  logic         clear_flags,
   input  logic [W-1:0] Data_A,
   input  logic [W-1:0] Data_B,
   output logic         valid_out,
   output logic         special_flag,
   output logic         zero_m_flag,
   output logic         inf_flag,
   output logic         nan_flag,
   output logic         invalid_flag,
   output logic [W-1:0] special_result,
   output logic         sticky_invalid,
   output logic         sticky_nan
);

   // Stage payload: {invalid, nan, inf, zero, result}
   localparam int unsigned PW = W + 4;

   logic [EW-1:0] exp_a, exp_b;
   logic [SW-1:0] frac_a, frac_b;
   logic          sign_r;
   logic          zero_a, zero_b, inf_a, inf_b, nan_a, nan_b, snan_a, snan_b;
   logic          zero_x_inf;

   assign exp_a  = Data_A[W-2:SW];
   assign exp_b  = Data_B[W-2:SW];
   assign frac_a = Data_A[SW-1:0];
   assign frac_b = Data_B[SW-1:0];
   assign sign_r = Data_A[W-1] ^ Data_B[W-1];

   // Denormals fold into zero only when flushing.
   assign zero_a = (exp_a == '0) && ((frac_a == '0) || FTZ);
   assign zero_b = (exp_b == '0) && ((frac_b == '0) || FTZ);
   assign inf_a  = (&exp_a) && (frac_a == '0);
   assign inf_b  = (&exp_b) && (frac_b == '0);
   assign nan_a  = (&exp_a) && (frac_a != '0);
   assign nan_b  = (&exp_b) && (frac_b != '0);
   assign snan_a = nan_a && !frac_a[SW-1];
   assign snan_b = nan_b && !frac_b[SW-1];

   assign zero_x_inf = (zero_a && inf_b) || (inf_a && zero_b);

   logic         in_nan, in_inf, in_zero, in_invalid;
   logic [W-1:0] in_result;

   always_comb begin
      in_nan     = 1'b0;
      in_inf     = 1'b0;
      in_zero    = 1'b0;
      in_result  = '0;
      in_invalid = zero_x_inf || snan_a || snan_b;
      if (nan_a || nan_b || zero_x_inf) begin
         in_nan    = 1'b1;
         in_result = {1'b0, {EW{1'b1}}, 1'b1, {(SW-1){1'b0}}};
      end else if (inf_a || inf_b) begin
         in_inf    = 1'b1;
         in_result = {sign_r, {EW{1'b1}}, {SW{1'b0}}};
      end else if (zero_a || zero_b) begin
         in_zero   = 1'b1;
         in_result = {sign_r, {(W-1){1'b0}}};
      end
   end

   logic [STAGES-1:0] vld_q;
   logic [PW-1:0]     pipe_q [STAGES];

   // Data registers only load behind a valid bit, so outputs hold between results.
   always_ff @(posedge clk) begin
      if (rst) begin
         vld_q <= '0;
         for (int unsigned i = 0; i < STAGES; i++) begin
            pipe_q[i] <= '0;
         end
      end else begin
         vld_q[0] <= load;
         if (load) begin
            pipe_q[0] <= {in_invalid, in_nan, in_inf, in_zero, in_result};
         end
         for (int unsigned i = 1; i < STAGES; i++) begin
            vld_q[i] <= vld_q[i-1];
            if (vld_q[i-1]) begin
               pipe_q[i] <= pipe_q[i-1];
            end
         end
      end
   end

   assign valid_out = vld_q[STAGES-1];
   assign {invalid_flag, nan_flag, inf_flag, zero_m_flag, special_result} = pipe_q[STAGES-1];
   assign special_flag = zero_m_flag | inf_flag | nan_flag;

   logic sticky_invalid_q, sticky_invalid_d;
   logic sticky_nan_q, sticky_nan_d;

   // A flag arriving with clear_flags wins over the clear.
   always_comb begin
      sticky_invalid_d = (sticky_invalid_q & ~clear_flags) | (valid_out & invalid_flag);
      sticky_nan_d     = (sticky_nan_q & ~clear_flags) | (valid_out & nan_flag);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         sticky_invalid_q <= 1'b0;
         sticky_nan_q     <= 1'b0;
      end else begin
         sticky_invalid_q <= sticky_invalid_d;
         sticky_nan_q     <= sticky_nan_d;
      end
   end

   assign sticky_invalid = sticky_invalid_q;
   assign sticky_nan     = sticky_nan_q;

endmodule

// File: tb/tb_special_case_mult_unit.sv
// Bench for special_case_mult_unit: three instances (STAGES=1/FTZ=1, STAGES=1/FTZ=0,
// STAGES=3/FTZ=1) share stimulus and are compared every cycle against a queue-based model.
module tb_special_case_mult_unit;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        load = 1'b0;
   logic        clear_flags = 1'b0;
   logic [31:0] Data_A = '0;
   logic [31:0] Data_B = '0;

   logic [2:0]  vo, sf, zf, inff, nf, invf, si, sn;
   logic [31:0] res [3];

   int checks = 0;
   int errors = 0;
   bit checking = 1'b0;

   always #5 clk = ~clk;

   special_case_mult_unit #(.W(32), .EW(8), .SW(23), .STAGES(1), .FTZ(1'b1)) u_d0 (
      .clk(clk), .rst(rst), .load(load), .clear_flags(clear_flags),
      .Data_A(Data_A), .Data_B(Data_B), .valid_out(vo[0]), .special_flag(sf[0]),
      .zero_m_flag(zf[0]), .inf_flag(inff[0]), .nan_flag(nf[0]), .invalid_flag(invf[0]),
      .special_result(res[0]), .sticky_invalid(si[0]), .sticky_nan(sn[0]));

   special_case_mult_unit #(.W(32), .EW(8), .SW(23), .STAGES(1), .FTZ(1'b0)) u_d1 (
      .clk(clk), .rst(rst), .load(load), .clear_flags(clear_flags),
      .Data_A(Data_A), .Data_B(Data_B), .valid_out(vo[1]), .special_flag(sf[1]),
      .zero_m_flag(zf[1]), .inf_flag(inff[1]), .nan_flag(nf[1]), .invalid_flag(invf[1]),
      .special_result(res[1]), .sticky_invalid(si[1]), .sticky_nan(sn[1]));

   special_case_mult_unit #(.W(32), .EW(8), .SW(23), .STAGES(3), .FTZ(1'b1)) u_d2 (
      .clk(clk), .rst(rst), .load(load), .clear_flags(clear_flags),
      .Data_A(Data_A), .Data_B(Data_B), .valid_out(vo[2]), .special_flag(sf[2]),
      .zero_m_flag(zf[2]), .inf_flag(inff[2]), .nan_flag(nf[2]), .invalid_flag(invf[2]),
      .special_result(res[2]), .sticky_invalid(si[2]), .sticky_nan(sn[2]));

   typedef struct packed {
      logic [31:0] r;
      logic        zero;
      logic        inf;
      logic        nan;
      logic        inv;
   } exp_t;

   function automatic exp_t model(input logic [31:0] a, input logic [31:0] b, input bit ftz);
      exp_t e;
      int   ea, eb, fa, fb;
      bit   a_nan, b_nan, a_inf, b_inf, a_zero, b_zero, neg;
      ea = int'(a[30:23]);
      eb = int'(b[30:23]);
      fa = int'(a[22:0]);
      fb = int'(b[22:0]);
      a_nan  = (ea == 255) && (fa != 0);
      b_nan  = (eb == 255) && (fb != 0);
      a_inf  = (ea == 255) && (fa == 0);
      b_inf  = (eb == 255) && (fb == 0);
      a_zero = (ea == 0) && ((fa == 0) || ftz);
      b_zero = (eb == 0) && ((fb == 0) || ftz);
      neg    = (a[31] != b[31]);
      e = '0;
      e.inv = (a_zero && b_inf) || (a_inf && b_zero) ||
              (a_nan && fa < 'h400000) || (b_nan && fb < 'h400000);
      if (a_nan || b_nan || (a_zero && b_inf) || (a_inf && b_zero)) begin
         e.nan = 1'b1;
         e.r   = 32'h7FC0_0000;
      end else if (a_inf || b_inf) begin
         e.inf = 1'b1;
         e.r   = neg ? 32'hFF80_0000 : 32'h7F80_0000;
      end else if (a_zero || b_zero) begin
         e.zero = 1'b1;
         e.r    = neg ? 32'h8000_0000 : 32'h0000_0000;
      end
      return e;
   endfunction

   task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s: got %08h expected %08h", nm, got, want);
      end
   endtask

   task automatic chk1(input string nm, input logic got, input logic want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s: got %b expected %b", nm, got, want);
      end
   endtask

   // Model: per-instance queue of pending results tagged with the cycle they must appear in.
   int   stg [3] = '{1, 1, 3};
   bit   ftz [3] = '{1'b1, 1'b0, 1'b1};
   exp_t pend [3][8];
   int   pdue [3][8];
   int   head [3] = '{0, 0, 0};
   int   tail [3] = '{0, 0, 0};
   exp_t held [3];
   bit   st_inv [3] = '{0, 0, 0};
   bit   st_nan [3] = '{0, 0, 0};
   int   cyc = 0;

   always @(posedge clk) begin
      for (int i = 0; i < 3; i++) begin
         if (rst) begin
            head[i] = 0;
            tail[i] = 0;
            held[i] = '0;
            st_inv[i] = 1'b0;
            st_nan[i] = 1'b0;
         end else begin
            if (head[i] != tail[i] && pdue[i][head[i] % 8] == cyc) begin
               held[i]   = pend[i][head[i] % 8];
               st_inv[i] = (st_inv[i] && !clear_flags) || held[i].inv;
               st_nan[i] = (st_nan[i] && !clear_flags) || held[i].nan;
               head[i]++;
            end else if (clear_flags) begin
               st_inv[i] = 1'b0;
               st_nan[i] = 1'b0;
            end
            if (load) begin
               pend[i][tail[i] % 8] = model(Data_A, Data_B, ftz[i]);
               pdue[i][tail[i] % 8] = cyc + stg[i];
               tail[i]++;
            end
         end
      end
      cyc++;
   end

   always @(negedge clk) begin
      if (checking) begin
         for (int i = 0; i < 3; i++) begin
            bit   ev;
            exp_t e;
            ev = (head[i] != tail[i]) && (pdue[i][head[i] % 8] == cyc);
            e  = ev ? pend[i][head[i] % 8] : held[i];
            chk1($sformatf("d%0d c%0d valid_out", i, cyc), vo[i], ev);
            chk1($sformatf("d%0d c%0d special_flag", i, cyc), sf[i], e.zero | e.inf | e.nan);
            chk1($sformatf("d%0d c%0d zero_m_flag", i, cyc), zf[i], e.zero);
            chk1($sformatf("d%0d c%0d inf_flag", i, cyc), inff[i], e.inf);
            chk1($sformatf("d%0d c%0d nan_flag", i, cyc), nf[i], e.nan);
            chk1($sformatf("d%0d c%0d invalid_flag", i, cyc), invf[i], e.inv);
            chk($sformatf("d%0d c%0d special_result", i, cyc), res[i], e.r);
            chk1($sformatf("d%0d c%0d sticky_invalid", i, cyc), si[i], st_inv[i]);
            chk1($sformatf("d%0d c%0d sticky_nan", i, cyc), sn[i], st_nan[i]);
         end
      end
   end

   // Drives inputs for the cycle following the next rising edge.
   task automatic drive(input logic l, input logic [31:0] a, input logic [31:0] b,
                        input logic clr, input logic r);
      @(posedge clk);
      #1;
      load = l;
      Data_A = a;
      Data_B = b;
      clear_flags = clr;
      rst = r;
   endtask

   task automatic op(input logic [31:0] a, input logic [31:0] b);
      drive(1'b1, a, b, 1'b0, 1'b0);
   endtask

   task automatic idle(input int n);
      for (int k = 0; k < n; k++) drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
   endtask

   initial begin
      exp_t m;
      // Hand-computed pins on the model itself.
      m = model(32'h0000_0000, 32'h3F80_0000, 1'b1);
      chk("pin zero result", m.r, 32'h0000_0000);
      chk1("pin zero flag", m.zero, 1'b1);
      m = model(32'h8000_0000, 32'h7F80_0000, 1'b1);
      chk("pin zxinf result", m.r, 32'h7FC0_0000);
      chk1("pin zxinf invalid", m.inv, 1'b1);
      m = model(32'hFF80_0000, 32'h4000_0000, 1'b1);
      chk("pin neg inf", m.r, 32'hFF80_0000);
      m = model(32'h0000_0001, 32'h3F80_0000, 1'b0);
      chk1("pin denorm noftz", m.zero | m.inf | m.nan, 1'b0);
      m = model(32'h7FC0_0000, 32'h3F80_0000, 1'b1);
      chk1("pin qnan not invalid", m.inv, 1'b0);

      drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
      drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
      @(posedge clk);
      #1;
      checking = 1'b1;
      chk("reset result d0", res[0], 32'h0);
      chk1("reset valid d2", vo[2], 1'b0);

      op(32'h0000_0000, 32'h3F80_0000);
      op(32'h8000_0000, 32'h3F80_0000);
      idle(4);

      op(32'h8000_0000, 32'h7F80_0000);
      for (int k = 0; k < 5; k++) op(32'h3F80_0000, 32'h4000_0000);
      idle(4);
      chk1("sticky_invalid held", si[0], 1'b1);
      drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
      idle(1);
      chk1("sticky_invalid cleared", si[0], 1'b0);

      op(32'hFF80_0000, 32'h4000_0000);
      op(32'h7F80_0001, 32'h3F80_0000);
      op(32'h0000_0001, 32'h3F80_0000);
      op(32'h3F80_0000, 32'h4000_0000);
      op(32'h7FC0_0000, 32'h0000_0000);
      op(32'h7F80_0000, 32'h0000_0000);
      op(32'h7F80_0000, 32'hFF80_0000);
      op(32'h3F80_0000, 32'h8000_0000);
      idle(5);

      // Back-to-back burst through the 3-stage instance.
      op(32'h0000_0000, 32'h3F80_0000);
      op(32'h7F80_0000, 32'h3F80_0000);
      op(32'h3F80_0000, 32'h4000_0000);
      idle(6);
      chk1("burst last held d2", inff[2], 1'b0);

      // Reset on the second cycle of a burst kills everything in flight.
      op(32'h8000_0000, 32'h7F80_0000);
      drive(1'b1, 32'h7F80_0000, 32'h3F80_0000, 1'b0, 1'b1);
      idle(5);
      chk1("post-rst valid d2", vo[2], 1'b0);
      chk("post-rst result d2", res[2], 32'h0);
      chk1("post-rst sticky d2", si[2], 1'b0);

      // clear_flags coinciding with a NaN result: the set wins.
      op(32'h7FC0_0000, 32'h3F80_0000);
      drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
      idle(1);
      chk1("set beats clear", sn[0], 1'b1);
      drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
      idle(1);
      chk1("clear alone", sn[0], 1'b0);
      idle(5);

      checking = 1'b0;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/special_case_mult_unit.md
Name: special_case_mult_unit

Overview:
- Parametrised special-operand detector for the FP multiplier datapath; successor to the single-flag zero-operand detector.
- Classifies both full IEEE-754 operands as zero, denormal, infinity or NaN.
- Produces the final special-case product word plus per-case flags through a configurable pipeline with a valid strobe.
- Keeps sticky exception flags for the FPU interface; the normal-path multiplier is bypassed whenever special_flag=1.

Parameters:
- W, 32, total word width (32 single, 64 double).
- EW, 8, exponent width (11 for double).
- SW, 23, fraction width (52 for double); W = 1+EW+SW is required.
- STAGES, 1, pipeline latency in cycles, legal range 1..3.
- FTZ, 1, 1 = denormal operands are treated as zero; 0 = denormals are ordinary (non-special).

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- load  in  1  operand strobe; Data_A and Data_B are sampled when load=1.
- clear_flags  in  1  clears the sticky flags.
- Data_A  in  W  operand A {sign, exp, frac}.
- Data_B  in  W  operand B.
- valid_out  out  1  one-cycle pulse when a result appears.
- special_flag  out  1  result is special (zero/inf/NaN); the normal path is to be ignored.
- zero_m_flag  out  1  result is signed zero.
- inf_flag  out  1  result is signed infinity.
- nan_flag  out  1  result is quiet NaN.
- invalid_flag  out  1  0 x inf, or a signalling NaN input.
- special_result  out  W  special product word (valid when special_flag=1).
- sticky_invalid  out  1  accumulated invalid_flag.
- sticky_nan  out  1  accumulated nan_flag.

Behaviour:
- Reset: rst is sampled at a clk edge. All pipeline valid bits, data registers, outputs and sticky flags go to 0. Reset mid-pipeline discards all in-flight operations; no valid_out follows.
- Operand classification (per operand, combinational, ahead of stage 1):
  - zero: exp==0 and frac==0.
  - denormal: exp==0 and frac!=0; counts as zero when FTZ=1, otherwise not special.
  - inf: exp all-ones and frac==0.
  - NaN: exp all-ones and frac!=0.
  - sNaN: NaN with frac MSB==0.
- Result priority, highest first:
  1. Any NaN operand, or zero x inf in either order -> nan_flag=1. special_result = canonical qNaN {0, all-ones, 1, zeros}, i.e. 0x7FC00000 for W=32.
  2. invalid_flag=1 when zero x inf, or when either operand is sNaN.
  3. Either operand inf -> inf_flag=1, special_result = {sA^sB, all-ones, zeros}.
  4. Either operand zero -> zero_m_flag=1, special_result = {sA^sB, zeros}.
  5. Otherwise all flags 0, special_result=0.
- special_flag = zero_m_flag | inf_flag | nan_flag. The flags zero_m_flag, inf_flag and nan_flag are mutually exclusive.
- Pipeline:
  - A valid bit shifts through STAGES registers every cycle.
  - Stage data registers capture only when their incoming valid bit is 1.
  - Result appears STAGES cycles after the load edge, with valid_out=1 for exactly that cycle.
  - Output data and flags hold their last value until the next result; they are not cleared when valid_out drops.
  - Back-to-back loads on consecutive cycles give consecutive valid_out pulses, in order, with no stall and no loss.
- Sticky flags:
  - Update only in a valid_out cycle: sticky_x <= sticky_x | x.
  - clear_flags=1 clears them on the next edge.
  - If clear_flags coincides with a valid_out cycle carrying x=1, the set wins and sticky_x=1.
  - clear_flags has no effect on the pipeline.
- load while rst=1 is ignored.

Test Plan:
- W=32, STAGES=1, load A=0x00000000, B=0x3F800000 -> next cycle valid_out=1, zero_m_flag=1, special_result=0x00000000; sign check with A=0x80000000 -> special_result=0x80000000.
- A=0x80000000, B=0x7F800000 -> nan_flag=1, invalid_flag=1, special_result=0x7FC00000, sticky_invalid=1; sticky_invalid stays 1 through five subsequent normal ops until clear_flags.
- A=0xFF800000, B=0x40000000 -> inf_flag=1, special_result=0xFF800000. Then A=0x7F800001 (sNaN), B=0x3F800000 -> nan_flag=1, invalid_flag=1, special_result=0x7FC00000.
- A=0x00000001, B=0x3F800000 -> with FTZ=1: zero_m_flag=1; with FTZ=0: special_flag=0. Also A=0x3F800000, B=0x40000000 -> all flags 0.
- STAGES=3: loads on cycles 0, 1 and 2 (zero, inf, normal) -> valid_out on cycles 3, 4 and 5 with matching flags. Assert rst on cycle 1 of a second burst -> no valid_out, all outputs 0.
- clear_flags asserted in the same cycle as a valid_out carrying nan_flag=1 -> sticky_nan=1 afterwards. clear_flags alone on the next cycle -> sticky_nan=0.
